// File: rtl/seg7_scan_display.sv
// Multiplexed NUM_DIGITS hex display driver. It double-buffers the shown value and
// swaps buffers only at a frame wrap, so a scan never shows two different values.
module seg7_scan_display #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 1000,
  parameter int ACTIVE_LOW_AN = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  output logic [6:0]                seg,
  output logic                      dp_n,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (ACTIVE_LOW_AN != 0) ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic [CW-1:0]           r_count;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_flag;
  logic [4*NUM_DIGITS-1:0] r_disp_val;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [6:0]              r_seg;
  logic                    r_dp_n;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic                    w_run;
  logic                    w_blank_cur;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign w_tick = enable && (r_count == COUNT_MAX);
  assign w_wrap = w_tick && (r_idx == IDX_MAX);

  always_comb begin
    w_nib    = 4'h0;
    w_dp     = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib       = r_disp_val[4*i +: 4];
        w_dp        = r_disp_dp[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // A digit is blankable when it and all digits above it are zero; digit 0 never is.
  always_comb begin
    w_blank = '0;
    w_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_run      = w_run & (r_disp_val[4*i +: 4] == 4'h0);
      w_blank[i] = w_run;
    end
  end

  assign w_blank_cur = blank_lz & (|(w_blank & w_onehot));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_idx   <= '0;
    end else if (enable) begin
      if (w_tick) begin
        r_count <= '0;
        r_idx   <= w_wrap ? '0 : r_idx + IW'(1);
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  // frame_done is registered like the display outputs: it is high in the cycle
  // following the wrap edge that swapped the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_flag  <= 1'b0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_wrap && load) begin
        r_disp_val   <= value;
        r_disp_dp    <= dp_in;
        r_pend_flag  <= 1'b0;
        r_frame_done <= 1'b1;
      end else if (w_wrap && r_pend_flag) begin
        r_disp_val   <= r_pend_val;
        r_disp_dp    <= r_pend_dp;
        r_pend_flag  <= 1'b0;
        r_frame_done <= 1'b1;
      end else if (load) begin
        r_pend_val  <= value;
        r_pend_dp   <= dp_in;
        r_pend_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      r_seg  <= SEG_OFF;
      r_dp_n <= 1'b1;
      r_an   <= AN_OFF;
    end else begin
      r_seg  <= w_blank_cur ? SEG_OFF : hex_to_seg(w_nib);
      r_dp_n <= ~w_dp;
      r_an   <= AN_OFF ^ w_onehot;
    end
  end

  assign seg        = r_seg;
  assign dp_n       = r_dp_n;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display (4 digits, 4 cycles per digit, active-low anodes):
// frame table plus hand sequences for wrap-coincident load, enable gating and reset.
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_done;

  seg7_scan_display #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(4),
    .ACTIVE_LOW_AN(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .load(load),
    .value(value),
    .dp_in(dp_in),
    .blank_lz(blank_lz),
    .seg(seg),
    .dp_n(dp_n),
    .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // One displayed frame: value, dp, blank_lz, expected segs {d3,d2,d1,d0}, expected dp_n
  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic        blz;
    logic [27:0] segs;
    logic [3:0]  dpn;
  } frame_t;

  localparam logic [12:0] DARK = {4'b1111, 7'b1111111, 1'b1, 1'b0};

  logic [12:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  frame_t tab [8];
  frame_t f_1111, f_2222, f_zero;

  task automatic step();
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic do_load(input frame_t f);
    load  = 1'b1;
    value = f.val;
    dp_in = f.dp;
  endtask

  task automatic push_digit(input int d, input frame_t f, input logic fd);
    logic [3:0] one;
    one = 4'b0001 << d;
    exp_q.push_back({4'b1111 ^ one, f.segs[7*d +: 7], f.dpn[d], fd});
  endtask

  task automatic check_pop(input string name);
    logic [12:0] got;
    logic [12:0] exp;
    got = {an, seg, dp_n, frame_done};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: expected queue empty, got an=%b seg=%b dp_n=%b fd=%b", name, an, seg, dp_n, frame_done);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_errors++;
        $display("FAIL %s: got an=%b seg=%b dp_n=%b fd=%b, expected an=%b seg=%b dp_n=%b fd=%b",
                 name, an, seg, dp_n, frame_done, exp[12:9], exp[8:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic wait_fd(input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      step();
      if (frame_done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL wait_fd: no frame_done within %0d cycles, got 0 required 1", bound);
    end
  endtask

  // Entered right after the sample that follows a wrap edge; sample j shows digit (j-1)/4.
  task automatic run_frame(input frame_t f, input logic fd_end, input int n,
                           input int ja, input frame_t la, input int jb, input frame_t lb);
    blank_lz = f.blz;
    for (int j = 1; j <= 16; j++) push_digit((j - 1) / 4, f, (j == 16) ? fd_end : 1'b0);
    for (int j = 1; j <= n; j++) begin
      step();
      check_pop($sformatf("frame_%h_j%0d", f.val, j));
      if (j == ja) do_load(la);
      if (j == jb) do_load(lb);
    end
    exp_q.delete();
  endtask

  initial begin
    tab[0] = '{16'h4567, 4'b0010, 1'b0, {7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111}, 4'b1101};
    tab[1] = '{16'h89AB, 4'b0000, 1'b0, {7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000}, 4'b1111};
    tab[2] = '{16'h0040, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1001100, 7'b0000001}, 4'b1111};
    tab[3] = '{16'h0000, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b1111};
    tab[4] = '{16'h0000, 4'b1001, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b0110};
    tab[5] = '{16'hCDEF, 4'b1111, 1'b0, {7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000}, 4'b0000};
    tab[6] = '{16'h0123, 4'b0000, 1'b1, {7'b1111111, 7'b1001111, 7'b0010010, 7'b0000110}, 4'b1111};
    tab[7] = '{16'h1000, 4'b0000, 1'b1, {7'b1001111, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111};
    f_1111 = '{16'h1111, 4'b0000, 1'b0, {4{7'b1001111}}, 4'b1111};
    f_2222 = '{16'h2222, 4'b0000, 1'b0, {4{7'b0010010}}, 4'b1111};
    f_zero = '{16'h0000, 4'b0000, 1'b0, {4{7'b0000001}}, 4'b1111};

    reset = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;

    // Reset held, then idle with enable low: everything dark
    for (int i = 0; i < 3; i++) begin
      step(); exp_q.push_back(DARK); check_pop("reset_hold");
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(); exp_q.push_back(DARK); check_pop("idle_disabled");
    end

    // First load rides in on the first wrap, then walk the frame table;
    // each entry is loaded mid-frame (idx=1) and must appear only on the next frame.
    do_load(tab[0]);
    enable = 1'b1;
    wait_fd(40);
    for (int k = 0; k < 8; k++) begin
      run_frame(tab[k], (k < 7), 16, (k < 7) ? 5 : -1, tab[(k < 7) ? k + 1 : k], -1, tab[0]);
    end

    // Two loads in one frame: the later one wins
    run_frame(tab[7], 1'b1, 16, 3, f_1111, 10, f_2222);
    // Load on the wrap cycle itself goes straight to display
    run_frame(f_2222, 1'b1, 16, 15, tab[0], -1, tab[0]);

    // Enable gating while digit 1 is lit
    blank_lz = 1'b0;
    for (int j = 1; j <= 6; j++) push_digit((j - 1) / 4, tab[0], 1'b0);
    for (int j = 1; j <= 6; j++) begin step(); check_pop("pre_gate"); end
    enable = 1'b0;
    for (int j = 0; j < 7; j++) begin
      exp_q.push_back(DARK); step(); check_pop("gated_dark");
    end
    enable = 1'b1;
    push_digit(1, tab[0], 1'b0);
    push_digit(1, tab[0], 1'b0);
    for (int j = 0; j < 4; j++) push_digit(2, tab[0], 1'b0);
    for (int j = 0; j < 4; j++) push_digit(3, tab[0], 1'b0);
    for (int j = 0; j < 10; j++) begin step(); check_pop("resume"); end

    // Reset during digit 2 with a load pending; pending must be discarded
    run_frame(tab[0], 1'b0, 9, 3, tab[1], -1, tab[0]);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(); exp_q.push_back(DARK); check_pop("reset_mid");
    end
    reset = 1'b0;
    run_frame(f_zero, 1'b0, 16, -1, tab[0], -1, tab[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
